// File: rtl/axi_frame_reader_if.sv
// -----------------------------------------------------------------------------
// axi_frame_reader_if
// Read-only AXI4 bus (AR + R channels) between the frame reader and PS DDR.
//   master modport : drives AR channel and rready, receives R channel.
//   slave  modport : the opposite view (memory side / testbench model).
// Signal names keep the m_axi_* spelling of the original flat port list.
// -----------------------------------------------------------------------------
interface axi_frame_reader_if;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   modport master (
      output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arvalid, m_axi_rready,
      input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid
   );

   modport slave (
      input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arvalid, m_axi_rready,
      output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid
   );
endinterface

// File: rtl/axi_frame_reader.sv
// -----------------------------------------------------------------------------
// axi_frame_reader
// AXI4 read master: on each frame_start fetches one RGB565 frame from DDR with
// fixed-length INCR bursts (one outstanding) and writes it, one pixel per
// cycle, into the async pixel FIFO. Runs entirely in the AXI clock domain.
//
// Ports
//   clk, rst        AXI clock; asynchronous active-high reset
//   frame_start     one-cycle start pulse (ignored while busy)
//   m_axi           AXI4 AR/R channels (axi_frame_reader_if.master)
//   fifo_din        RGB565 pixel to the FIFO
//   fifo_wr_en      FIFO write strobe
//   fifo_prog_full  FIFO has fewer than one burst of free entries
//   busy            frame fetch in progress
//   frame_done      one-cycle pulse after the last pixel of a frame
//   err             sticky error (bad rresp / misplaced or missing rlast)
//   cur_buf         buffer being fetched (only with FRAME_PINGPONG_EN)
//
// Build option
//   FRAME_PINGPONG_EN : alternate between two frame buffers; buffer 1 sits
//                       H_PIXELS*V_LINES*2 bytes above FRAME_BASE.
// -----------------------------------------------------------------------------
module axi_frame_reader #(
   parameter logic [31:0] FRAME_BASE = 32'h1000_0000,
   parameter int unsigned H_PIXELS   = 320,
   parameter int unsigned V_LINES    = 240,
   parameter int unsigned BURST_LEN  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame_start,
   axi_frame_reader_if.master        m_axi,
   output logic [15:0]               fifo_din,
   output logic                      fifo_wr_en,
   input  logic                      fifo_prog_full,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      err
`ifdef FRAME_PINGPONG_EN
   ,
   output logic                      cur_buf
`endif
);

   localparam int unsigned TOTAL_BURSTS = (H_PIXELS * V_LINES) / (4 * BURST_LEN);
   localparam int unsigned BURST_BYTES  = BURST_LEN * 8;
   localparam int unsigned BIDX_W       = (TOTAL_BURSTS > 1) ? $clog2(TOTAL_BURSTS) : 1;
   localparam int unsigned BEAT_W       = $clog2(BURST_LEN + 1);

   localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(TOTAL_BURSTS - 1);
   localparam logic [BEAT_W-1:0] ALL_BEATS = BEAT_W'(BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
`ifdef FRAME_PINGPONG_EN
   localparam logic [31:0]       BUF_BYTES = 32'(H_PIXELS * V_LINES * 2);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BIDX_W-1:0]   r_burst_idx;
   logic [BEAT_W-1:0]   r_beat_cnt;
   logic [63:0]         r_hold;
   logic                r_hold_vld;
   logic [1:0]          r_pix_idx;
   logic                r_err;

   logic                w_arvalid;
   logic [31:0]         w_araddr;
   logic                w_rready;
   logic                w_ar_hs;
   logic                w_r_hs;
   logic                w_pix_last;
   logic                w_burst_end;
   logic                w_beat_err;
   logic [31:0]         w_base;

`ifdef FRAME_PINGPONG_EN
   logic                r_buf_sel;
   assign w_base  = r_buf_sel ? (FRAME_BASE + BUF_BYTES) : FRAME_BASE;
   assign cur_buf = r_buf_sel;
`else
   assign w_base  = FRAME_BASE;
`endif

   assign w_ar_hs     = w_arvalid & m_axi.m_axi_arready;
   assign w_r_hs      = m_axi.m_axi_rvalid & w_rready;
   assign w_pix_last  = r_hold_vld & (r_pix_idx == 2'd3);
   // Burst is complete once all beats are in and the final pixel of the last
   // beat is being written this cycle. Counting beats (rather than trusting
   // rlast) keeps the FSM moving even when the slave gets rlast wrong.
   assign w_burst_end = (r_state == S_DATA) & (r_beat_cnt == ALL_BEATS) & w_pix_last;

   assign w_beat_err  = (m_axi.m_axi_rresp != 2'b00)
                      | ( m_axi.m_axi_rlast & (r_beat_cnt != LAST_BEAT))
                      | (!m_axi.m_axi_rlast & (r_beat_cnt == LAST_BEAT));

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      w_arvalid   = 1'b0;
      w_araddr    = '0;
      w_rready    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (frame_start) w_state_nxt = S_CHECK;
         end
         S_CHECK: begin
            if (!fifo_prog_full) w_state_nxt = S_ADDR;
         end
         S_ADDR: begin
            w_arvalid = 1'b1;
            w_araddr  = w_base + (32'(r_burst_idx) * BURST_BYTES);
            if (m_axi.m_axi_arready) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            // Take a new beat when the holder is empty or is emptying now;
            // this gives back-to-back pixels at one beat per four cycles.
            w_rready = (r_beat_cnt != ALL_BEATS) & (!r_hold_vld | w_pix_last);
            if (w_burst_end)
               w_state_nxt = (r_burst_idx == LAST_BIDX) ? S_DONE : S_CHECK;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_burst_idx <= '0;
         r_beat_cnt  <= '0;
         r_hold      <= '0;
         r_hold_vld  <= 1'b0;
         r_pix_idx   <= '0;
         r_err       <= 1'b0;
`ifdef FRAME_PINGPONG_EN
         r_buf_sel   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;

         if ((r_state == S_IDLE) && frame_start)
            r_burst_idx <= '0;
         else if (w_burst_end && (r_burst_idx != LAST_BIDX))
            r_burst_idx <= r_burst_idx + BIDX_W'(1);

         if (w_ar_hs)
            r_beat_cnt <= '0;
         else if (w_r_hs)
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);

         if (w_r_hs) begin
            r_hold     <= m_axi.m_axi_rdata;
            r_hold_vld <= 1'b1;
            r_pix_idx  <= '0;
         end else if (r_hold_vld) begin
            r_pix_idx <= r_pix_idx + 2'd1;
            if (w_pix_last) r_hold_vld <= 1'b0;
         end

         if (w_r_hs && w_beat_err) r_err <= 1'b1;

`ifdef FRAME_PINGPONG_EN
         if (r_state == S_DONE) r_buf_sel <= ~r_buf_sel;
`endif
      end
   end

   // ---------------------------------------------------------------- outputs
   assign m_axi.m_axi_arvalid = w_arvalid;
   assign m_axi.m_axi_araddr  = w_araddr;
   assign m_axi.m_axi_arlen   = 8'(BURST_LEN - 1);
   assign m_axi.m_axi_arsize  = 3'b011;
   assign m_axi.m_axi_arburst = 2'b01;
   assign m_axi.m_axi_rready  = w_rready;

   assign fifo_wr_en = r_hold_vld;
   assign fifo_din   = r_hold_vld ? r_hold[{r_pix_idx, 4'b0000} +: 16] : '0;
   assign busy       = (r_state != S_IDLE);
   assign frame_done = (r_state == S_DONE);
   assign err        = r_err;

endmodule

// File: tb/tb_axi_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_axi_frame_reader
// Directed bench for axi_frame_reader using a reduced 64x8 frame (8 bursts,
// 512 pixels) so every scenario runs whole frames in a few hundred cycles.
// A memory model answers AR requests with 16 beats whose pixels encode their
// own byte offset: pixel value = (offset from FRAME_BASE)/2 + 1.
// Build with FRAME_PINGPONG_EN defined to exercise the double-buffer option.
// -----------------------------------------------------------------------------
module tb_axi_frame_reader;
   localparam logic [31:0] BASE     = 32'h1000_0000;
   localparam int unsigned HP       = 64;
   localparam int unsigned VL       = 8;
   localparam int unsigned BL       = 16;
   localparam int unsigned NBURST   = 8;
   localparam int unsigned NPIX     = 512;
   localparam logic [31:0] BUF1_OFS = 32'h0000_0400;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic        fifo_prog_full;
   logic [15:0] fifo_din;
   logic        fifo_wr_en;
   logic        busy;
   logic        frame_done;
   logic        err;
`ifdef FRAME_PINGPONG_EN
   logic        cur_buf;
`endif

   axi_frame_reader_if axi ();

   always #5 clk = ~clk;

   axi_frame_reader #(
      .FRAME_BASE (BASE),
      .H_PIXELS   (HP),
      .V_LINES    (VL),
      .BURST_LEN  (BL)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .frame_start    (frame_start),
      .m_axi          (axi),
      .fifo_din       (fifo_din),
      .fifo_wr_en     (fifo_wr_en),
      .fifo_prog_full (fifo_prog_full),
      .busy           (busy),
      .frame_done     (frame_done),
      .err            (err)
`ifdef FRAME_PINGPONG_EN
      ,
      .cur_buf        (cur_buf)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitor state
   int          cyc = 0;
   int          ar_cnt, step_errs, attr_errs, wr_cnt, pix_errs, done_cnt;
   int          arv_in_win, curbuf_errs, first_r_cyc, first_wr_cyc;
   logic [31:0] ar_q[$];
   logic [15:0] first_din[4];
   logic        first_rdy[4];
   int          first_cyc[4];
   logic [15:0] exp_pix;
   logic        exp_buf;
   logic        win;
   int          inj_resp_burst, inj_resp_beat, inj_last_burst, inj_last_beat;

   function automatic logic pp(input logic b);
`ifdef FRAME_PINGPONG_EN
      return b;
`else
      return 1'b0 & b;
`endif
   endfunction

   function automatic logic [31:0] base_of(input logic b);
      return BASE + (b ? BUF1_OFS : 32'h0);
   endfunction

   function automatic logic [31:0] get_addr(input int i);
      if (ar_q.size() > i) return ar_q[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic clear_mon(input logic b);
      @(posedge clk); #2;
      ar_cnt = 0; step_errs = 0; attr_errs = 0; wr_cnt = 0; pix_errs = 0;
      done_cnt = 0; arv_in_win = 0; curbuf_errs = 0;
      first_r_cyc = -1; first_wr_cyc = -1;
      ar_q.delete();
      exp_buf = b;
      exp_pix = 16'((base_of(b) - BASE) >> 1) + 16'd1;
      for (int i = 0; i < 4; i++) begin
         first_din[i] = '0; first_rdy[i] = 1'b0; first_cyc[i] = 0;
      end
   endtask

   // ---------------------------------------------------------------- memory model + monitor
   initial begin
      logic        ar_hs, r_hs;
      logic [31:0] hs_addr, s_addr;
      int          hs_bnum, s_bnum, s_beat;
      logic        s_active;
      logic [15:0] p;
      s_active = 1'b0; s_addr = '0; s_beat = 0; s_bnum = 0; hs_addr = '0; hs_bnum = 0;
      axi.m_axi_arready = 1'b1;
      axi.m_axi_rvalid  = 1'b0;
      axi.m_axi_rdata   = '0;
      axi.m_axi_rresp   = 2'b00;
      axi.m_axi_rlast   = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         ar_hs = axi.m_axi_arvalid & axi.m_axi_arready;
         r_hs  = axi.m_axi_rvalid & axi.m_axi_rready;
         if (ar_hs) begin
            if (ar_cnt > 0 && axi.m_axi_araddr != ar_q[ar_cnt-1] + 32'h80) step_errs++;
            if (axi.m_axi_arlen != 8'd15 || axi.m_axi_arsize != 3'b011 ||
                axi.m_axi_arburst != 2'b01) attr_errs++;
            ar_q.push_back(axi.m_axi_araddr);
            hs_addr = axi.m_axi_araddr;
            hs_bnum = ar_cnt;
            ar_cnt++;
         end
         if (r_hs && first_r_cyc < 0) first_r_cyc = cyc;
         if (fifo_wr_en) begin
            if (wr_cnt < 4) begin
               first_din[wr_cnt] = fifo_din;
               first_rdy[wr_cnt] = axi.m_axi_rready;
               first_cyc[wr_cnt] = cyc;
            end
            if (wr_cnt == 0) first_wr_cyc = cyc;
            if (fifo_din !== exp_pix) pix_errs++;
            exp_pix = exp_pix + 16'd1;
            wr_cnt++;
         end
         if (frame_done) done_cnt++;
         if (win && axi.m_axi_arvalid) arv_in_win++;
`ifdef FRAME_PINGPONG_EN
         if (busy && cur_buf !== exp_buf) curbuf_errs++;
`endif
         @(posedge clk); #1;
         if (rst) begin
            s_active = 1'b0;
         end else begin
            if (r_hs) begin
               s_beat++;
               if (s_beat == BL) s_active = 1'b0;
            end
            if (ar_hs) begin
               s_active = 1'b1; s_addr = hs_addr; s_beat = 0; s_bnum = hs_bnum;
            end
         end
         if (s_active) begin
            p = 16'(((s_addr + 32'(s_beat) * 8) - BASE) >> 1) + 16'd1;
            axi.m_axi_rvalid = 1'b1;
            axi.m_axi_rdata  = {p + 16'd3, p + 16'd2, p + 16'd1, p};
            axi.m_axi_rresp  = (s_bnum == inj_resp_burst && s_beat == inj_resp_beat) ? 2'b10 : 2'b00;
            if (s_bnum == inj_last_burst) axi.m_axi_rlast = (s_beat == inj_last_beat);
            else                          axi.m_axi_rlast = (s_beat == BL - 1);
         end else begin
            axi.m_axi_rvalid = 1'b0;
            axi.m_axi_rdata  = '0;
            axi.m_axi_rresp  = 2'b00;
            axi.m_axi_rlast  = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic pulse_start();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int k = 0;
      while (done_cnt < 1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, 64'(done_cnt >= 1), 64'd1);
   endtask

   task automatic wait_ar(input int n, input int budget, input string tag);
      int k = 0;
      while (ar_cnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, 64'(ar_cnt >= n), 64'd1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_arvalid"}, axi.m_axi_arvalid, 0);
      check({tag, "_araddr"},  axi.m_axi_araddr,  0);
      check({tag, "_rready"},  axi.m_axi_rready,  0);
      check({tag, "_wr_en"},   fifo_wr_en,        0);
      check({tag, "_din"},     fifo_din,          0);
      check({tag, "_busy"},    busy,              0);
      check({tag, "_done"},    frame_done,        0);
      check({tag, "_err"},     err,               0);
   endtask

   task automatic check_frame(input string tag, input logic b, input logic exp_err);
      check({tag, "_ar_cnt"},     ar_cnt,      NBURST);
      check({tag, "_first_addr"}, get_addr(0), base_of(b));
      check({tag, "_last_addr"},  get_addr(NBURST-1), base_of(b) + 32'h380);
      check({tag, "_step_errs"},  step_errs,   0);
      check({tag, "_attr_errs"},  attr_errs,   0);
      check({tag, "_wr_cnt"},     wr_cnt,      NPIX);
      check({tag, "_pix_errs"},   pix_errs,    0);
      check({tag, "_done_cnt"},   done_cnt,    1);
      check({tag, "_err"},        err,         exp_err);
      check({tag, "_busy_after"}, busy,        0);
`ifdef FRAME_PINGPONG_EN
      check({tag, "_cur_buf"},    curbuf_errs, 0);
`endif
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      int n;
      rst = 1'b1; frame_start = 1'b0; fifo_prog_full = 1'b0; win = 1'b0;
      inj_resp_burst = -1; inj_resp_beat = -1; inj_last_burst = -1; inj_last_beat = -1;
      ar_cnt = 0; wr_cnt = 0; done_cnt = 0; exp_pix = '0; exp_buf = 1'b0;
      step_errs = 0; attr_errs = 0; pix_errs = 0; arv_in_win = 0; curbuf_errs = 0;
      first_r_cyc = -1; first_wr_cyc = -1;

      repeat (3) @(negedge clk);
      check_quiet("rst0");
      check("rst0_arlen",   axi.m_axi_arlen,   8'd15);
      check("rst0_arsize",  axi.m_axi_arsize,  3'b011);
      check("rst0_arburst", axi.m_axi_arburst, 2'b01);
      @(posedge clk); #1 rst = 1'b0;

      // Frame 1: plain fetch, unpack order and first-beat latency
      clear_mon(pp(1'b0));
      pulse_start();
      wait_done(3000, "f1_done_seen");
      repeat (3) @(negedge clk);
      check_frame("f1", pp(1'b0), 1'b0);
      check("f1_first4_din", {first_din[3], first_din[2], first_din[1], first_din[0]},
            64'h0004_0003_0002_0001);
      check("f1_first4_rready", {first_rdy[3], first_rdy[2], first_rdy[1], first_rdy[0]}, 4'b1000);
      check("f1_first4_consec", first_cyc[3] - first_cyc[0], 3);
      check("f1_wr_latency", first_wr_cyc - first_r_cyc, 1);

      // Frame 2: ignored extra start, prog_full stall after burst 5
      clear_mon(pp(1'b1));
      pulse_start();
      wait_ar(3, 1000, "f2_ar3_seen");
      pulse_start();
      wait_ar(6, 1000, "f2_ar6_seen");
      @(posedge clk); #1 fifo_prog_full = 1'b1; win = 1'b1;
      repeat (100) @(posedge clk);
      #1 fifo_prog_full = 1'b0; win = 1'b0;
      wait_done(3000, "f2_done_seen");
      repeat (3) @(negedge clk);
      check_frame("f2", pp(1'b1), 1'b0);
      check("f2_arvalid_in_stall", arv_in_win, 0);
      check("f2_resume_addr", get_addr(6), base_of(pp(1'b1)) + 32'h300);

      // Frame 3: reset in the middle of a burst
      clear_mon(pp(1'b0));
      pulse_start();
      wait_ar(2, 1000, "f3_ar2_seen");
      repeat (10) @(posedge clk);
      #1;
      check("f3_busy_pre_rst", busy, 1);
      check("f3_wr_en_pre_rst", fifo_wr_en, 1);
      rst = 1'b1;
      @(negedge clk);
      check_quiet("f3_rst");
      @(posedge clk); #1 rst = 1'b0;
      n = ar_cnt;
      repeat (30) @(negedge clk);
      check("f3_no_restart", ar_cnt, n);
      check("f3_busy_post_rst", busy, 0);

      // Frame 4: rresp error on burst 0 beat 7, restart from FRAME_BASE
      clear_mon(1'b0);
      inj_resp_burst = 0; inj_resp_beat = 7;
      pulse_start();
      wait_done(3000, "f4_done_seen");
      repeat (3) @(negedge clk);
      check_frame("f4", 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      check("f4_err_sticky", err, 1);
      inj_resp_burst = -1; inj_resp_beat = -1;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("f4_err_cleared", err, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Frame 5: early rlast on burst 2 beat 5 (and none on beat 15)
      clear_mon(1'b0);
      inj_last_burst = 2; inj_last_beat = 5;
      pulse_start();
      wait_done(3000, "f5_done_seen");
      repeat (3) @(negedge clk);
      check_frame("f5", 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_frame_reader.md
Name: axi_frame_reader

Overview:
- AXI4 read master that fetches one 320x240 RGB565 frame per trigger from PS DDR and pushes it, one pixel per write, into the async pixel FIFO.
- The video timing generator drains that FIFO in the pixel clock domain.
- Runs entirely in the AXI clock domain.
- Issues fixed-length INCR bursts with one burst outstanding at a time.
- Flow control uses the FIFO's programmable-full flag.

Parameters:
FRAME_BASE, 32'h1000_0000, byte address of the frame in DDR; must be 4 KB aligned
H_PIXELS, 320, pixels per line
V_LINES, 240, lines per frame
BURST_LEN, 16, beats per burst; 64-bit beats, so 64 pixels and 128 bytes per burst

Ports:
clk  in  1  AXI clock
rst  in  1  asynchronous active-high reset
frame_start  in  1  one-cycle pulse; already synchronised to clk (derived from vsync)
m_axi_araddr  out  32  burst start address
m_axi_arlen  out  8  constant BURST_LEN-1
m_axi_arsize  out  3  constant 3'b011 (8 bytes)
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rdata  in  64  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
fifo_din  out  16  RGB565 pixel
fifo_wr_en  out  1  FIFO write strobe
fifo_prog_full  in  1  asserts when free space is below 64 entries
busy  out  1  frame fetch in progress
frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
err  out  1  sticky error flag

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Values during reset: all outputs 0 except the constants arlen, arsize and arburst; burst counter, beat counter and unpack register cleared; state IDLE.
- Frame size: TOTAL_BURSTS = H_PIXELS*V_LINES/(4*BURST_LEN), which is 1200 at the defaults.
- State machine:
  - IDLE: on frame_start, clear burst_idx, set busy, go to CHECK.
  - CHECK: if fifo_prog_full is 0, go to ADDR; otherwise stay.
  - ADDR: arvalid=1, araddr = FRAME_BASE + burst_idx*128. araddr is stable while arvalid is high. On arready, drop arvalid and go to DATA.
  - DATA: accept beats. After the rlast beat is accepted and fully unpacked:
    - if burst_idx == TOTAL_BURSTS-1, go to DONE;
    - otherwise increment burst_idx and go to CHECK.
  - DONE: pulse frame_done for one cycle, clear busy, go to IDLE.
- Unpack:
  - A 64-bit holding register with a 2-bit pixel index.
  - Pixel order is [15:0], [31:16], [47:32], [63:48], i.e. lowest address first.
  - Each cycle with held data: fifo_wr_en=1, fifo_din = current pixel.
  - rready = (holding register empty) OR (pixel index 3 being written this cycle). This sustains 1 beat per 4 cycles with no bubbles.
  - The FIFO is never written while holding is empty. prog_full is not consulted mid-burst; the threshold guarantees space.
- Errors set err, which clears only on rst:
  - rresp != 0 on any accepted beat;
  - rlast on a beat other than beat BURST_LEN-1;
  - rlast missing on beat BURST_LEN-1.
- Error data is still unpacked and written, keeping the FIFO pixel count exact.
- frame_start while busy is ignored; no restart and no error.
- Reset mid-burst aborts immediately, with no completion of the outstanding burst. The interconnect is reset together with this block.
- Latency: first fifo_wr_en occurs 1 cycle after the first accepted R beat.

Optional Feature:
- Macro FRAME_PINGPONG_EN.
- When defined:
  - An internal buf_sel register (reset 0) toggles in DONE.
  - Base address is FRAME_BASE + buf_sel*H_PIXELS*V_LINES*2, i.e. +153600 bytes for buffer 1.
  - An extra output port cur_buf (1 bit) equals buf_sel for the fetch in progress.
- When undefined: base is always FRAME_BASE, and cur_buf does not exist.

Test Plan:
- Reset then a single frame_start, slave with arready/rvalid always 1:
  - exactly 1200 AR handshakes, addresses 0x1000_0000 through 0x1002_57 80 step 0x80 (last = 0x1002_5780), arlen=15;
  - 76800 fifo_wr_en pulses;
  - one frame_done; err=0.
- Beat data 0x0004_0003_0002_0001 -> fifo_din sequence 1,2,3,4 on 4 consecutive cycles; rready low during pixels 0-2 and high on pixel 3.
- Hold fifo_prog_full=1 after burst 5 for 100 cycles -> no arvalid during that window; resumes at address FRAME_BASE+0x300 after release.
- rresp=2'b10 on beat 7 of burst 0 -> err set and stays 1 through frame_done; pixel count is still 76800.
- frame_start pulsed mid-frame, then rst pulsed in DATA:
  - the extra pulse changes nothing;
  - after rst, all outputs are 0 and the next frame_start restarts at FRAME_BASE.
- FRAME_PINGPONG_EN defined, two frames -> second frame's first araddr = 0x1002_5800; cur_buf goes 0 then 1.
